// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Purpose:
//    Converts a simple valid/ready request interface into APB transfers on
//    one of NUM_SLAVES slave ports. The slave is chosen by a 4-bit index
//    field of the request address, starting at bit SEL_LSB. An index with no
//    matching slave is answered at once with an error and never reaches the
//    bus. A slave that holds PREADY low for TIMEOUT_CYCLES access cycles is
//    abandoned with an error response. At most one transfer is outstanding.
//
// Parameters:
//    NUM_SLAVES      number of slave ports (1..16)
//    SEL_LSB         lowest req_addr bit of the slave index field
//    TIMEOUT_CYCLES  maximum ACCESS-phase cycles before abort (0 = never)
//
// Ports:
//    clk           clock, all logic on the rising edge
//    n_rst         synchronous active-low reset
//    req_valid     request present
//    req_ready     master accepts a request this cycle (IDLE only)
//    req_write     1 = write, 0 = read
//    req_addr      byte address
//    req_wdata     write data
//    resp_valid    one-cycle completion pulse
//    resp_rdata    read data (0 for writes and errors), held until next resp
//    resp_err      decode error or timeout, held until next resp
//    PADDR         APB address
//    PWDATA        APB write data
//    PWRITE        APB direction
//    PENABLE       APB access phase
//    PSEL          one-hot slave select
//    PRDATA        packed per-slave read data, slave i at [i*32 +: 32]
//    PREADY        per-slave ready
// ---------------------------------------------------------------------------
module apb_master #(
   parameter int NUM_SLAVES     = 4,
   parameter int SEL_LSB        = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [31:0]              req_addr,
   input  logic [31:0]              req_wdata,
   output logic                     resp_valid,
   output logic [31:0]              resp_rdata,
   output logic                     resp_err,
   output logic [31:0]              PADDR,
   output logic [31:0]              PWDATA,
   output logic                     PWRITE,
   output logic                     PENABLE,
   output logic [NUM_SLAVES-1:0]    PSEL,
   input  logic [NUM_SLAVES*32-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]    PREADY
);

   // Wait counter only has to reach TIMEOUT_CYCLES-1.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] LAST_WAIT =
      CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_nxt;

   logic                   ready_q;
   logic                   accept;
   logic [3:0]             idx;
   logic                   idx_ok;
   logic [NUM_SLAVES-1:0]  sel_dec;
   logic [NUM_SLAVES-1:0]  sel_q;
   logic                   sel_ready;
   logic [31:0]            sel_rdata;
   logic [CNT_W-1:0]       wait_cnt;
   logic                   timeout_hit;

   assign accept = req_valid & ready_q;
   assign idx    = req_addr[SEL_LSB+3:SEL_LSB];
   assign idx_ok = ({1'b0, idx} < 5'(NUM_SLAVES));

   // Address decode to a one-hot select; all zeros when the index is invalid.
   always_comb begin
      sel_dec = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         sel_dec[i] = (idx == 4'(i));
      end
   end

   // Only the selected slave's PREADY/PRDATA can reach the FSM.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) begin
            sel_ready = sel_ready | PREADY[i];
            sel_rdata = sel_rdata | PRDATA[i*32 +: 32];
         end
      end
   end

   // Abort on the TIMEOUT_CYCLES-th not-ready access cycle; ready wins.
   assign timeout_hit = TIMEOUT_EN && (state == ACCESS) && !sel_ready &&
                        (wait_cnt == LAST_WAIT);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = idx_ok ? SETUP : RESP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (sel_ready || timeout_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // req_ready is registered so it reads 0 while reset is held and rises on
   // the first edge after reset release, in step with the IDLE state.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= (state_nxt == IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         PADDR      <= '0;
         PWDATA     <= '0;
         PWRITE     <= 1'b0;
         sel_q      <= '0;
         wait_cnt   <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
            PWRITE <= req_write;
            sel_q  <= idx_ok ? sel_dec : '0;
            if (!idx_ok) begin
               resp_err   <= 1'b1;
               resp_rdata <= '0;
            end
         end
         if (state == SETUP) begin
            wait_cnt <= '0;
         end
         if (state == ACCESS) begin
            if (sel_ready) begin
               resp_err   <= 1'b0;
               resp_rdata <= PWRITE ? 32'h0 : sel_rdata;
            end else if (timeout_hit) begin
               resp_err   <= 1'b1;
               resp_rdata <= '0;
            end else begin
               wait_cnt <= wait_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Bus control is a pure decode of the state register.
   assign req_ready  = ready_q;
   assign PSEL       = ((state == SETUP) || (state == ACCESS)) ? sel_q : '0;
   assign PENABLE    = (state == ACCESS);
   assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//
// Directed bench for apb_master with the default parameters (4 slaves,
// SEL_LSB 12, 16-cycle timeout). Inputs are driven and outputs sampled 1 ns
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_apb_master;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic [31:0]   paddr;
   logic [31:0]   pwdata;
   logic          pwrite;
   logic          penable;
   logic [3:0]    psel;
   logic [127:0]  prdata;
   logic [3:0]    pready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   apb_master #(
      .NUM_SLAVES     (4),
      .SEL_LSB        (12),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .PADDR      (paddr),
      .PWDATA     (pwdata),
      .PWRITE     (pwrite),
      .PENABLE    (penable),
      .PSEL       (psel),
      .PRDATA     (prdata),
      .PREADY     (pready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one request. The selected slave (slv < 4) raises PREADY in ACCESS
   // cycle ready_at (0 = never); other slaves keep PREADY=1. lat is the cycle
   // index after the accept edge in which resp_valid was seen (100 = none).
   task automatic do_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int slv,
                          input int ready_at, output int acc, output int lat,
                          output logic [3:0] psel_or, output int psel_cyc);
      int w;
      w = 0;
      while (!req_ready && w < 20) begin
         tick();
         w++;
      end
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      if (slv < 4) pready[slv] = 1'b0;
      tick();
      req_valid = 1'b0;
      acc = 0;
      lat = 1;
      psel_or = '0;
      psel_cyc = 0;
      while (!resp_valid && lat < 100) begin
         if (penable) acc++;
         if (psel != 0) psel_cyc++;
         psel_or = psel_or | psel;
         if (slv < 4) pready[slv] = (ready_at != 0) && (acc >= ready_at);
         tick();
         lat++;
      end
      if (slv < 4) pready[slv] = 1'b1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      pready    = 4'hF;
      prdata    = '0;
      tick();
      tick();
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %0h want 0", req_ready); end
      n_checks++; if (psel !== 4'h0 || penable !== 1'b0) begin n_fail++; $display("FAIL reset_bus got psel=%0h penable=%0h want 0/0", psel, penable); end
      n_checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp got v=%0h e=%0h d=%0h want 0", resp_valid, resp_err, resp_rdata); end
      n_checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) begin n_fail++; $display("FAIL reset_addr got a=%0h d=%0h w=%0h want 0", paddr, pwdata, pwrite); end
      n_rst = 1'b1;
      tick();
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %0h want 1", req_ready); end
   endtask

   task automatic test_read_wait();
      int acc, lat, pc;
      logic [3:0] po;
      prdata[3*32 +: 32] = 32'hDEAD_BEEF;
      prdata[2*32 +: 32] = 32'hBAD0_0002;
      do_xfer(1'b0, 32'h0000_3010, 32'h0, 3, 4, acc, lat, po, pc);
      n_checks++; if (acc !== 4) begin n_fail++; $display("FAIL read_wait_access got %0d want 4", acc); end
      n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL read_wait_latency got %0d want 6", lat); end
      n_checks++; if (po !== 4'b1000 || pc !== 5) begin n_fail++; $display("FAIL read_wait_psel got %0h/%0d want 8/5", po, pc); end
      n_checks++; if (resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0) begin n_fail++; $display("FAIL read_wait_resp got d=%0h e=%0h want deadbeef/0", resp_rdata, resp_err); end
      n_checks++; if (paddr !== 32'h0000_3010 || pwrite !== 1'b0) begin n_fail++; $display("FAIL read_wait_paddr got %0h/%0h want 3010/0", paddr, pwrite); end
   endtask

   task automatic test_write();
      int w;
      w = 0;
      while (!req_ready && w < 20) begin tick(); w++; end
      pready    = 4'hF;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_1004;
      req_wdata = 32'h0000_00A5;
      tick();
      req_valid = 1'b0;
      n_checks++; if (psel !== 4'b0010 || penable !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL write_setup got psel=%0h en=%0h v=%0h want 2/0/0", psel, penable, resp_valid); end
      n_checks++; if (paddr !== 32'h1004 || pwdata !== 32'hA5 || pwrite !== 1'b1) begin n_fail++; $display("FAIL write_bus got a=%0h d=%0h w=%0h want 1004/a5/1", paddr, pwdata, pwrite); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL write_busy_ready got %0h want 0", req_ready); end
      tick();
      n_checks++; if (psel !== 4'b0010 || penable !== 1'b1) begin n_fail++; $display("FAIL write_access got psel=%0h en=%0h want 2/1", psel, penable); end
      tick();
      n_checks++; if (resp_valid !== 1'b1 || psel !== 4'h0 || penable !== 1'b0) begin n_fail++; $display("FAIL write_resp got v=%0h psel=%0h en=%0h want 1/0/0", resp_valid, psel, penable); end
      n_checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL write_resp_data got e=%0h d=%0h want 0/0", resp_err, resp_rdata); end
      tick();
      n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL write_idle got v=%0h rdy=%0h want 0/1", resp_valid, req_ready); end
      n_checks++; if (paddr !== 32'h1004 || pwdata !== 32'hA5 || pwrite !== 1'b1) begin n_fail++; $display("FAIL write_retain got a=%0h d=%0h w=%0h want 1004/a5/1", paddr, pwdata, pwrite); end
   endtask

   task automatic test_decode_err();
      int acc, lat, pc;
      logic [3:0] po;
      do_xfer(1'b0, 32'h0000_5000, 32'h0, 5, 0, acc, lat, po, pc);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL decode_latency got %0d want 1", lat); end
      n_checks++; if (po !== 4'h0 || acc !== 0) begin n_fail++; $display("FAIL decode_psel got %0h/%0d want 0/0", po, acc); end
      n_checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL decode_resp got e=%0h d=%0h want 1/0", resp_err, resp_rdata); end
      tick();
      n_checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b1) begin n_fail++; $display("FAIL decode_hold got v=%0h e=%0h want 0/1", resp_valid, resp_err); end
   endtask

   task automatic test_timeout();
      int acc, lat, pc;
      logic [3:0] po;
      prdata[1*32 +: 32] = 32'h0BAD_F00D;
      do_xfer(1'b0, 32'h0000_1000, 32'h0, 1, 0, acc, lat, po, pc);
      n_checks++; if (acc !== 16 || lat !== 18) begin n_fail++; $display("FAIL timeout_cycles got acc=%0d lat=%0d want 16/18", acc, lat); end
      n_checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_resp got e=%0h d=%0h want 1/0", resp_err, resp_rdata); end
      do_xfer(1'b0, 32'h0000_1008, 32'h0, 1, 16, acc, lat, po, pc);
      n_checks++; if (acc !== 16 || lat !== 18) begin n_fail++; $display("FAIL ready_last_cycles got acc=%0d lat=%0d want 16/18", acc, lat); end
      n_checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL ready_last_resp got e=%0h d=%0h want 0/badf00d", resp_err, resp_rdata); end
   endtask

   task automatic test_reset_mid();
      int acc, lat, pc, w;
      logic [3:0] po;
      logic seen;
      w = 0;
      while (!req_ready && w < 20) begin tick(); w++; end
      pready[2] = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_2000;
      tick();
      req_valid = 1'b0;
      tick();
      n_checks++; if (penable !== 1'b1 || psel !== 4'b0100) begin n_fail++; $display("FAIL mid_access got en=%0h psel=%0h want 1/4", penable, psel); end
      n_rst = 1'b0;
      tick();
      n_checks++; if (psel !== 4'h0 || penable !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset got psel=%0h en=%0h v=%0h want 0/0/0", psel, penable, resp_valid); end
      n_rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (resp_valid) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp got %0h want 0", seen); end
      pready[2] = 1'b1;
      prdata[2*32 +: 32] = 32'h1234_5678;
      do_xfer(1'b0, 32'h0000_2008, 32'h0, 2, 1, acc, lat, po, pc);
      n_checks++; if (lat !== 3 || resp_rdata !== 32'h1234_5678 || resp_err !== 1'b0) begin n_fail++; $display("FAIL mid_after got lat=%0d d=%0h e=%0h want 3/12345678/0", lat, resp_rdata, resp_err); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [3];
      logic [31:0] exp_d [3];
      int acc_t [3];
      int rsp_t [3];
      logic [31:0] rsp_d [3];
      int k, t, nr, w;
      logic take, bad;
      addrs[0] = 32'h0000_0000; exp_d[0] = 32'h1111_0000;
      addrs[1] = 32'h0000_1004; exp_d[1] = 32'h2222_0001;
      addrs[2] = 32'h0000_2008; exp_d[2] = 32'h3333_0002;
      for (int i = 0; i < 3; i++) begin
         prdata[i*32 +: 32] = exp_d[i];
         acc_t[i] = -100;
         rsp_t[i] = -1;
         rsp_d[i] = '0;
      end
      pready = 4'hF;
      w = 0;
      while (!req_ready && w < 20) begin tick(); w++; end
      k = 0; t = 0; nr = 0; bad = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = addrs[0];
      while ((k < 3 || nr < 3) && t < 60) begin
         if (req_ready && (psel != 0 || resp_valid)) bad = 1'b1;
         if (resp_valid) begin
            if (nr < 3) begin rsp_t[nr] = t; rsp_d[nr] = resp_rdata; end
            nr++;
         end
         take = req_ready && req_valid;
         tick();
         if (take) begin
            if (k < 3) acc_t[k] = t;
            k++;
            if (k < 3) req_addr = addrs[k];
            else req_valid = 1'b0;
         end
         t++;
      end
      req_valid = 1'b0;
      n_checks++; if (k !== 3 || nr !== 3) begin n_fail++; $display("FAIL b2b_count got acc=%0d resp=%0d want 3/3", k, nr); end
      n_checks++; if (acc_t[1] - acc_t[0] !== 4 || acc_t[2] - acc_t[1] !== 4) begin n_fail++; $display("FAIL b2b_spacing got %0d,%0d want 4,4", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]); end
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_idle_only got %0h want 0", bad); end
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (rsp_d[i] !== exp_d[i] || rsp_t[i] - acc_t[i] !== 3) begin n_fail++; $display("FAIL b2b_resp%0d got d=%0h lat=%0d want %0h/3", i, rsp_d[i], rsp_t[i] - acc_t[i], exp_d[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_read_wait();
      test_write();
      test_decode_err();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_SLAVES, 4, number of PSEL/PRDATA/PREADY slave ports (1..16)
  SEL_LSB, 12, lowest req_addr bit of the slave index field (4 KB window per slave)
  TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort (0 = never abort)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  clock, all logic on rising edge
  n_rst  in  1  reset, synchronous, active-low
  req_valid  in  1  request present
  req_ready  out  1  master accepts request this cycle
  req_write  in  1  1 = write, 0 = read
  req_addr  in  32  byte address
  req_wdata  in  32  write data
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  32  read data, valid with resp_valid
  resp_err  out  1  decode error or timeout, valid with resp_valid
  PADDR  out  32  APB address
  PWDATA  out  32  APB write data
  PWRITE  out  1  APB direction
  PENABLE  out  1  APB access phase
  PSEL  out  NUM_SLAVES  one-hot slave select
  PRDATA  in  NUM_SLAVES x 32  packed per-slave read data
  PREADY  in  NUM_SLAVES  per-slave ready; tie 1 for zero-wait slaves
REQ-003 Reset SHALL be synchronous and active-low on n_rst, sampled on the rising edge of clk, which is the only clock.

Function
REQ-004 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP; one transfer outstanding at most.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-006 On accept, the master SHALL register req_addr->PADDR, req_wdata->PWDATA, req_write->PWRITE and idx = req_addr[SEL_LSB+3:SEL_LSB].
REQ-007 If idx >= NUM_SLAVES, the FSM SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0; no PSEL is asserted.
REQ-008 Otherwise IDLE->SETUP: PSEL[idx]=1, PENABLE=0 for exactly one cycle; then SETUP->ACCESS: PSEL[idx]=1, PENABLE=1.
REQ-009 In ACCESS, PADDR, PWDATA, PWRITE and PSEL SHALL stay stable until the transfer ends.
REQ-010 ACCESS SHALL end on the edge where PREADY[idx]=1; on a read, PRDATA[idx] SHALL be captured into resp_rdata on that edge; resp_err=0; next state RESP.
REQ-011 A wait counter SHALL clear on entering ACCESS and increment on each ACCESS cycle with PREADY[idx]=0.
REQ-012 If TIMEOUT_CYCLES>0 and the ACCESS cycle with PREADY[idx]=0 is the TIMEOUT_CYCLES-th such cycle, the FSM SHALL go to RESP with resp_err=1 and resp_rdata=0; the ACCESS phase lasts at most TIMEOUT_CYCLES cycles.
REQ-013 PREADY=1 in the final permitted cycle SHALL complete normally; ready wins over timeout.
REQ-014 In RESP, resp_valid SHALL be 1 for exactly one cycle, PSEL=0 and PENABLE=0; the next state is IDLE.
REQ-015 resp_rdata SHALL be 0 for writes; resp_rdata and resp_err SHALL hold their value until the next RESP.
REQ-016 PSEL and PENABLE SHALL be 0 in IDLE and RESP; PADDR, PWDATA and PWRITE retain their last values there.
REQ-017 PREADY and PRDATA of non-selected slaves SHALL be ignored.
REQ-018 Minimum transfer SHALL be accept edge + SETUP + ACCESS + RESP: resp_valid 3 cycles after the accept edge; back-to-back accept no sooner than 4 cycles apart.

Reset
REQ-019 While n_rst=0 at a rising edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 (req_ready=1 after the first edge with n_rst=1, IDLE), including during a mid-transfer SETUP or ACCESS, with no resp_valid issued for the aborted transfer.

Verification
REQ-020 The bench SHALL cover these scenarios:
  Write 0xA5 to 0x0000_1004, PREADY tied 1 -> PSEL=0b0010 for 2 cycles, PENABLE high 1 cycle, PADDR=0x1004, PWDATA=0xA5, resp_valid 3 cycles after accept, resp_err=0.
  Read 0x0000_3010, slave 3 PRDATA=0xDEAD_BEEF, PREADY low 3 cycles -> ACCESS lasts 4 cycles, resp_rdata=0xDEAD_BEEF, resp_err=0.
  Read 0x0000_5000 with NUM_SLAVES=4 -> no PSEL, resp_valid 1 cycle after accept, resp_err=1, resp_rdata=0.
  PREADY held 0, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then resp_err=1; PREADY=1 on the 16th cycle -> normal completion instead.
  n_rst low during ACCESS -> next edge: PSEL=0, PENABLE=0, resp_valid never pulses; a new request is accepted afterward.
  req_valid held high for 3 requests -> each accepted only in IDLE, 4 cycles apart, responses in order.
